// File: rtl/pool_downsample.sv
// Purpose : streaming FACTORxFACTOR window pooler (decimate / max / min) for a
//           raster-scanned IMG_W x IMG_H frame; one accumulator per output column.
// Latency : one clock from the last pixel of a window to out_vld.
// Backpressure: none; accepts one pixel per in_vld cycle, every out_vld pulse
//           must be consumed by the downstream block.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   sync_clr          synchronous frame resync (beats counters, mode, out_vld)
//   mode              0 decimate, 1 max, 2 min, 3 treated as decimate
//   in_data, in_vld   input pixel stream, gaps allowed
//   out_data, out_vld pooled pixel, single-cycle pulse; out_data is 0 when idle
//   out_sof, out_eof  first / last output pixel of the frame
//   out_col, out_row  output pixel coordinates, meaningful only with out_vld
module pool_downsample #(
  parameter int DATA_W = 1,
  parameter int IMG_W  = 112,
  parameter int IMG_H  = 112,
  parameter int FACTOR = 4,
  localparam int OUT_W = IMG_W / FACTOR,
  localparam int OUT_H = IMG_H / FACTOR,
  localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1,
  localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sync_clr,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_vld,
  output logic [DATA_W-1:0] out_data,
  output logic              out_vld,
  output logic              out_sof,
  output logic              out_eof,
  output logic [COL_W-1:0]  out_col,
  output logic [ROW_W-1:0]  out_row
);

  localparam int K_W = $clog2(FACTOR);

  localparam logic [K_W-1:0]   K_LAST  = K_W'(FACTOR - 1);
  localparam logic [COL_W-1:0] WC_LAST = COL_W'(OUT_W - 1);
  localparam logic [ROW_W-1:0] WR_LAST = ROW_W'(OUT_H - 1);

  // The raster position is kept split into window index and window-local
  // offset, so col_cnt = wc*FACTOR + kx and row_cnt = wr*FACTOR + ky without
  // any divider in the datapath.
  logic [K_W-1:0]   kx;
  logic [K_W-1:0]   ky;
  logic [COL_W-1:0] wc;
  logic [ROW_W-1:0] wr;

  logic [1:0] mode_q;

  // One entry per output column, reused for every band of FACTOR lines.
  logic [DATA_W-1:0] acc [OUT_W];

  logic              beat;
  logic              kx_last;
  logic              ky_last;
  logic              wc_last;
  logic              wr_last;
  logic              first_px;
  logic              seed;
  logic              emit;
  logic              is_max;
  logic              is_min;
  logic [DATA_W-1:0] acc_rd;
  logic [DATA_W-1:0] pooled;

  // sync_clr wins over in_vld: the pixel presented with it is dropped.
  assign beat     = in_vld && !sync_clr;

  assign kx_last  = (kx == K_LAST);
  assign ky_last  = (ky == K_LAST);
  assign wc_last  = (wc == WC_LAST);
  assign wr_last  = (wr == WR_LAST);
  assign first_px = (kx == '0) && (ky == '0) && (wc == '0) && (wr == '0);
  assign seed     = (kx == '0) && (ky == '0);
  assign emit     = kx_last && ky_last;

  // Reserved mode 3 falls through to decimate.
  assign is_max   = (mode_q == 2'd1);
  assign is_min   = (mode_q == 2'd2);

  // acc is a register file: a write on one edge is visible to the read on the
  // next beat, which is exactly what back-to-back pixels of one window need.
  assign acc_rd   = acc[wc];

  always_comb begin
    pooled = acc_rd;
    if (is_max) begin
      pooled = (in_data > acc_rd) ? in_data : acc_rd;
    end else if (is_min) begin
      pooled = (in_data < acc_rd) ? in_data : acc_rd;
    end
  end

  // Accumulator storage carries no reset: every window is seeded by its
  // top-left pixel before it is ever read for a result.
  always_ff @(posedge clk) begin
    if (beat) begin
      acc[wc] <= seed ? in_data : pooled;
    end
  end

  // Raster position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kx <= '0;
      ky <= '0;
      wc <= '0;
      wr <= '0;
    end else if (sync_clr) begin
      kx <= '0;
      ky <= '0;
      wc <= '0;
      wr <= '0;
    end else if (in_vld) begin
      if (!kx_last) begin
        kx <= kx + K_W'(1);
      end else begin
        kx <= '0;
        if (!wc_last) begin
          wc <= wc + COL_W'(1);
        end else begin
          // End of an input line.
          wc <= '0;
          if (!ky_last) begin
            ky <= ky + K_W'(1);
          end else begin
            ky <= '0;
            wr <= wr_last ? '0 : wr + ROW_W'(1);
          end
        end
      end
    end
  end

  // Mode is sampled on the first pixel of a frame and held for the whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 2'd0;
    end else if (sync_clr) begin
      mode_q <= 2'd0;
    end else if (in_vld && first_px) begin
      mode_q <= mode;
    end
  end

  // Output register: data is zeroed whenever no pulse is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_sof  <= 1'b0;
      out_eof  <= 1'b0;
      out_col  <= '0;
      out_row  <= '0;
    end else begin
      out_vld  <= beat && emit;
      out_data <= (beat && emit) ? pooled : '0;
      out_sof  <= beat && emit && (wc == '0) && (wr == '0);
      out_eof  <= beat && emit && wc_last && wr_last;
      if (beat && emit) begin
        out_col <= wc;
        out_row <= wr;
      end
    end
  end

endmodule
